// File: rtl/vscale_hasti_arbiter_pkg.sv
// Shared types for the 2:1 HASTI arbiter: address-phase control bundle and request decode.
`include "vscale_hasti_constants.vh"

package vscale_hasti_arbiter_pkg;

  localparam int HTRANS_W = 2;
  localparam int HSIZE_W  = 3;
  localparam int HBURST_W = 3;
  localparam int HPROT_W  = 4;

  // Address-phase control fields; haddr travels alongside since its width is a parameter.
  typedef struct packed {
    logic                hwrite;
    logic [HSIZE_W-1:0]  hsize;
    logic [HBURST_W-1:0] hburst;
    logic                hmastlock;
    logic [HPROT_W-1:0]  hprot;
    logic [HTRANS_W-1:0] htrans;
  } ahb_ctl_t;

  function automatic logic trans_active(input logic [HTRANS_W-1:0] htrans);
    return (htrans == `HTRANS_NONSEQ) || (htrans == `HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/vscale_hasti_arb_hold.sv
// Per-master holding register for an accepted-but-not-granted address phase.
// Zero-latency bypass: sel_* shows the held copy while valid, else the live signals.
module vscale_hasti_arb_hold
  import vscale_hasti_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] live_addr_i,
  input  ahb_ctl_t              live_ctl_i,
  input  logic                  capture_i,
  input  logic                  release_i,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] sel_addr_o,
  output ahb_ctl_t              sel_ctl_o
);

  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  ahb_ctl_t              ctl_q;

  always_comb begin
    valid_d = valid_q;
    if (capture_i)      valid_d = 1'b1;
    else if (release_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (capture_i) begin
      addr_q <= live_addr_i;
      ctl_q  <= live_ctl_i;
    end
  end

  assign valid_o    = valid_q;
  assign sel_addr_o = valid_q ? addr_q : live_addr_i;
  assign sel_ctl_o  = valid_q ? ctl_q  : live_ctl_i;

endmodule

// File: rtl/vscale_hasti_constants.vh
// AHB-Lite (HASTI) encodings shared by the vscale bus blocks.
`ifndef VSCALE_HASTI_CONSTANTS_VH
`define VSCALE_HASTI_CONSTANTS_VH

`define HTRANS_IDLE    2'b00
`define HTRANS_BUSY    2'b01
`define HTRANS_NONSEQ  2'b10
`define HTRANS_SEQ     2'b11

`define HSIZE_BYTE     3'd0
`define HSIZE_HWORD    3'd1
`define HSIZE_WORD     3'd2

`define HBURST_SINGLE  3'd0
`define HBURST_INCR    3'd1

`endif

// File: rtl/vscale_hasti_arbiter.sv
// 2-master -> 1-slave AHB-Lite arbiter; zero added latency when uncontended.
// A losing master sees hready=0 while its address phase waits in its hold register.
`include "vscale_hasti_constants.vh"

module vscale_hasti_arbiter
  import vscale_hasti_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ROUND_ROBIN = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_haddr,
  input  logic                  m0_hwrite,
  input  logic [2:0]            m0_hsize,
  input  logic [2:0]            m0_hburst,
  input  logic                  m0_hmastlock,
  input  logic [3:0]            m0_hprot,
  input  logic [1:0]            m0_htrans,
  input  logic [DATA_WIDTH-1:0] m0_hwdata,
  output logic [DATA_WIDTH-1:0] m0_hrdata,
  output logic                  m0_hready,
  output logic                  m0_hresp,
  input  logic [ADDR_WIDTH-1:0] m1_haddr,
  input  logic                  m1_hwrite,
  input  logic [2:0]            m1_hsize,
  input  logic [2:0]            m1_hburst,
  input  logic                  m1_hmastlock,
  input  logic [3:0]            m1_hprot,
  input  logic [1:0]            m1_htrans,
  input  logic [DATA_WIDTH-1:0] m1_hwdata,
  output logic [DATA_WIDTH-1:0] m1_hrdata,
  output logic                  m1_hready,
  output logic                  m1_hresp,
  output logic [ADDR_WIDTH-1:0] s_haddr,
  output logic                  s_hwrite,
  output logic [2:0]            s_hsize,
  output logic [2:0]            s_hburst,
  output logic                  s_hmastlock,
  output logic [3:0]            s_hprot,
  output logic [1:0]            s_htrans,
  output logic [DATA_WIDTH-1:0] s_hwdata,
  input  logic [DATA_WIDTH-1:0] s_hrdata,
  input  logic                  s_hready,
  input  logic                  s_hresp
);

  logic [ADDR_WIDTH-1:0] live_addr [2];
  ahb_ctl_t              live_ctl  [2];
  logic [ADDR_WIDTH-1:0] sel_addr  [2];
  ahb_ctl_t              sel_ctl   [2];
  logic [1:0]            hold_valid, req, capture, release_h;
  logic                  dp_valid_q, dp_valid_d, dp_owner_q, dp_owner_d;
  logic                  rr_last_q, rr_last_d, lock_q, lock_d;
  logic                  dp_own0, dp_own1, win, gnt;
  ahb_ctl_t              s_ctl;

  assign live_addr[0] = m0_haddr;
  assign live_addr[1] = m1_haddr;
  assign live_ctl[0]  = '{hwrite: m0_hwrite, hsize: m0_hsize, hburst: m0_hburst,
                          hmastlock: m0_hmastlock, hprot: m0_hprot, htrans: m0_htrans};
  assign live_ctl[1]  = '{hwrite: m1_hwrite, hsize: m1_hsize, hburst: m1_hburst,
                          hmastlock: m1_hmastlock, hprot: m1_hprot, htrans: m1_htrans};

  assign dp_own0   = dp_valid_q & ~dp_owner_q;
  assign dp_own1   = dp_valid_q &  dp_owner_q;
  assign m0_hready = hold_valid[0] ? 1'b0 : (dp_own0 ? s_hready : 1'b1);
  assign m1_hready = hold_valid[1] ? 1'b0 : (dp_own1 ? s_hready : 1'b1);
  assign m0_hresp  = dp_own0 & s_hresp;
  assign m1_hresp  = dp_own1 & s_hresp;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;
  assign s_hwdata  = dp_owner_q ? m1_hwdata : m0_hwdata;

  assign req[0] = hold_valid[0] | (trans_active(m0_htrans) & m0_hready);
  assign req[1] = hold_valid[1] | (trans_active(m1_htrans) & m1_hready);

  // The candidate is computed during slave wait states too so the presented address
  // stays put; it is only committed (grant, data phase, hold release) while s_hready=1.
  always_comb begin
    win = 1'b0;
    if (lock_q && req[rr_last_q])      win = rr_last_q;
    else if (req[0] && req[1])         win = (ROUND_ROBIN != 0) ? ~rr_last_q : 1'b0;
    else if (req[1])                   win = 1'b1;
  end

  assign gnt = s_hready & (|req);

  assign capture[0]   = trans_active(m0_htrans) & m0_hready & ~(gnt & ~win);
  assign capture[1]   = trans_active(m1_htrans) & m1_hready & ~(gnt &  win);
  assign release_h[0] = hold_valid[0] & gnt & ~win;
  assign release_h[1] = hold_valid[1] & gnt &  win;

  always_comb begin
    s_haddr = sel_addr[win];
    s_ctl   = sel_ctl[win];
    if (req == 2'b00) begin
      s_haddr      = m1_haddr;
      s_ctl        = live_ctl[1];
      s_ctl.htrans = `HTRANS_IDLE;
    end
  end

  assign s_hwrite    = s_ctl.hwrite;
  assign s_hsize     = s_ctl.hsize;
  assign s_hburst    = s_ctl.hburst;
  assign s_hmastlock = s_ctl.hmastlock;
  assign s_hprot     = s_ctl.hprot;
  assign s_htrans    = s_ctl.htrans;

  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_owner_d = dp_owner_q;
    rr_last_d  = rr_last_q;
    lock_d     = lock_q;
    if (s_hready) begin
      dp_valid_d = gnt;
      if (gnt) begin
        dp_owner_d = win;
        rr_last_d  = win;
        lock_d     = s_ctl.hmastlock;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_valid_q <= 1'b0;
      dp_owner_q <= 1'b0;
      rr_last_q  <= 1'b1;
      lock_q     <= 1'b0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_owner_q <= dp_owner_d;
      rr_last_q  <= rr_last_d;
      lock_q     <= lock_d;
    end
  end

  vscale_hasti_arb_hold #(.ADDR_WIDTH(ADDR_WIDTH)) u_hold0 (
    .clk        (clk),
    .reset      (reset),
    .live_addr_i(live_addr[0]),
    .live_ctl_i (live_ctl[0]),
    .capture_i  (capture[0]),
    .release_i  (release_h[0]),
    .valid_o    (hold_valid[0]),
    .sel_addr_o (sel_addr[0]),
    .sel_ctl_o  (sel_ctl[0])
  );

  vscale_hasti_arb_hold #(.ADDR_WIDTH(ADDR_WIDTH)) u_hold1 (
    .clk        (clk),
    .reset      (reset),
    .live_addr_i(live_addr[1]),
    .live_ctl_i (live_ctl[1]),
    .capture_i  (capture[1]),
    .release_i  (release_h[1]),
    .valid_o    (hold_valid[1]),
    .sel_addr_o (sel_addr[1]),
    .sel_ctl_o  (sel_ctl[1])
  );

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Directed bench: fixed-priority arbiter plus a round-robin instance sharing the same stimulus.
`include "vscale_hasti_constants.vh"

module tb_vscale_hasti_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, s_hrdata;
  logic        m0_hwrite, m1_hwrite, m0_hmastlock, m1_hmastlock;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        s_hready, s_hresp;

  logic [31:0] m0_hrdata, m1_hrdata, s_haddr, s_hwdata;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp, s_hwrite, s_hmastlock;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;

  logic [31:0] r_m0_hrdata, r_m1_hrdata, r_s_haddr, r_s_hwdata;
  logic        r_m0_hready, r_m1_hready, r_m0_hresp, r_m1_hresp, r_s_hwrite, r_s_hmastlock;
  logic [2:0]  r_s_hsize, r_s_hburst;
  logic [3:0]  r_s_hprot;
  logic [1:0]  r_s_htrans;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vscale_hasti_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(0)) u_dut (
    .clk(clk), .reset(reset),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
    .m0_hmastlock(m0_hmastlock), .m0_hprot(m0_hprot), .m0_htrans(m0_htrans),
    .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
    .m1_hmastlock(m1_hmastlock), .m1_hprot(m1_hprot), .m1_htrans(m1_htrans),
    .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hmastlock(s_hmastlock), .s_hprot(s_hprot), .s_htrans(s_htrans), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  vscale_hasti_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1)) u_dut_rr (
    .clk(clk), .reset(reset),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
    .m0_hmastlock(m0_hmastlock), .m0_hprot(m0_hprot), .m0_htrans(m0_htrans),
    .m0_hwdata(m0_hwdata), .m0_hrdata(r_m0_hrdata), .m0_hready(r_m0_hready), .m0_hresp(r_m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
    .m1_hmastlock(m1_hmastlock), .m1_hprot(m1_hprot), .m1_htrans(m1_htrans),
    .m1_hwdata(m1_hwdata), .m1_hrdata(r_m1_hrdata), .m1_hready(r_m1_hready), .m1_hresp(r_m1_hresp),
    .s_haddr(r_s_haddr), .s_hwrite(r_s_hwrite), .s_hsize(r_s_hsize), .s_hburst(r_s_hburst),
    .s_hmastlock(r_s_hmastlock), .s_hprot(r_s_hprot), .s_htrans(r_s_htrans), .s_hwdata(r_s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic m0_req(input logic [31:0] addr, input logic wr);
    m0_haddr = addr; m0_hwrite = wr; m0_htrans = `HTRANS_NONSEQ;
  endtask

  task automatic m1_req(input logic [31:0] addr, input logic wr);
    m1_haddr = addr; m1_hwrite = wr; m1_htrans = `HTRANS_NONSEQ;
  endtask

  initial begin
    reset = 1'b1;
    m0_haddr = '0; m0_hwrite = 1'b0; m0_hsize = `HSIZE_WORD; m0_hburst = `HBURST_SINGLE;
    m0_hmastlock = 1'b0; m0_hprot = 4'h3; m0_htrans = `HTRANS_IDLE; m0_hwdata = '0;
    m1_haddr = '0; m1_hwrite = 1'b0; m1_hsize = `HSIZE_WORD; m1_hburst = `HBURST_SINGLE;
    m1_hmastlock = 1'b0; m1_hprot = 4'h3; m1_htrans = `HTRANS_IDLE; m1_hwdata = '0;
    s_hrdata = '0; s_hready = 1'b1; s_hresp = 1'b0;

    next_cycle();
    reset = 1'b0;
    sample();
    check("rst_htrans", 64'(s_htrans), 64'(`HTRANS_IDLE));
    check("rst_m0_hready", 64'(m0_hready), 64'd1);
    check("rst_m1_hready", 64'(m1_hready), 64'd1);
    check("rst_m0_hresp", 64'(m0_hresp), 64'd0);
    check("rst_m1_hresp", 64'(m1_hresp), 64'd0);

    // 1: uncontended m1 read passes straight through
    next_cycle();
    m1_req(32'h100, 1'b0);
    sample();
    check("t1_haddr", 64'(s_haddr), 64'h100);
    check("t1_htrans", 64'(s_htrans), 64'(`HTRANS_NONSEQ));
    check("t1_m1_hready_a", 64'(m1_hready), 64'd1);
    next_cycle();
    m1_htrans = `HTRANS_IDLE; s_hrdata = 32'h1111_2222;
    sample();
    check("t1_m1_hrdata", 64'(m1_hrdata), 64'h1111_2222);
    check("t1_m1_hready_d", 64'(m1_hready), 64'd1);

    // 2: simultaneous requests, m0 has priority, m1 held one cycle
    next_cycle();
    m0_req(32'h200, 1'b1); m1_req(32'h300, 1'b0);
    sample();
    check("t2_n_haddr", 64'(s_haddr), 64'h200);
    check("t2_n_hwrite", 64'(s_hwrite), 64'd1);
    check("t2_n_m1_hready", 64'(m1_hready), 64'd1);
    next_cycle();
    m0_htrans = `HTRANS_IDLE; m0_hwdata = 32'hDEAD_BEEF; m1_htrans = `HTRANS_IDLE;
    sample();
    check("t2_n1_m1_hready", 64'(m1_hready), 64'd0);
    check("t2_n1_haddr", 64'(s_haddr), 64'h300);
    check("t2_n1_hwrite", 64'(s_hwrite), 64'd0);
    check("t2_n1_hwdata", 64'(s_hwdata), 64'hDEAD_BEEF);
    check("t2_n1_m0_hready", 64'(m0_hready), 64'd1);
    next_cycle();
    s_hrdata = 32'h3333_0000;
    sample();
    check("t2_n2_m1_hready", 64'(m1_hready), 64'd1);
    check("t2_n2_m1_hrdata", 64'(m1_hrdata), 64'h3333_0000);
    check("t2_n2_htrans", 64'(s_htrans), 64'(`HTRANS_IDLE));

    // 3: slave wait states on m0 data phase while m1 issues 0x400
    next_cycle();
    m0_req(32'h500, 1'b1);
    sample();
    check("t3_haddr_m0", 64'(s_haddr), 64'h500);
    next_cycle();
    m0_htrans = `HTRANS_IDLE; m0_hwdata = 32'h5555; s_hready = 1'b0;
    m1_req(32'h400, 1'b0);
    sample();
    check("t3_w1_m0_hready", 64'(m0_hready), 64'd0);
    check("t3_w1_m1_hready", 64'(m1_hready), 64'd1);
    check("t3_w1_haddr", 64'(s_haddr), 64'h400);
    check("t3_w1_hwdata", 64'(s_hwdata), 64'h5555);
    next_cycle();
    m1_htrans = `HTRANS_IDLE;
    sample();
    check("t3_w2_m0_hready", 64'(m0_hready), 64'd0);
    check("t3_w2_m1_hready", 64'(m1_hready), 64'd0);
    check("t3_w2_haddr", 64'(s_haddr), 64'h400);
    next_cycle();
    s_hready = 1'b1;
    sample();
    check("t3_r_m0_hready", 64'(m0_hready), 64'd1);
    check("t3_r_haddr", 64'(s_haddr), 64'h400);
    check("t3_r_htrans", 64'(s_htrans), 64'(`HTRANS_NONSEQ));
    check("t3_r_m1_hready", 64'(m1_hready), 64'd0);
    next_cycle();
    sample();
    check("t3_d_m1_hready", 64'(m1_hready), 64'd1);
    check("t3_d_htrans", 64'(s_htrans), 64'(`HTRANS_IDLE));

    // 4: two-cycle ERROR response on m0 data phase
    next_cycle();
    m0_req(32'h600, 1'b0);
    sample();
    check("t4_haddr", 64'(s_haddr), 64'h600);
    next_cycle();
    m0_htrans = `HTRANS_IDLE; s_hready = 1'b0; s_hresp = 1'b1;
    sample();
    check("t4_e1_m0_hresp", 64'(m0_hresp), 64'd1);
    check("t4_e1_m0_hready", 64'(m0_hready), 64'd0);
    check("t4_e1_m1_hresp", 64'(m1_hresp), 64'd0);
    next_cycle();
    s_hready = 1'b1;
    sample();
    check("t4_e2_m0_hresp", 64'(m0_hresp), 64'd1);
    check("t4_e2_m0_hready", 64'(m0_hready), 64'd1);
    check("t4_e2_m1_hresp", 64'(m1_hresp), 64'd0);
    next_cycle();
    s_hresp = 1'b0;

    // 5: reset while m1 sits in its hold register
    m0_req(32'h700, 1'b0); m1_req(32'h800, 1'b0);
    sample();
    check("t5_haddr", 64'(s_haddr), 64'h700);
    next_cycle();
    m0_htrans = `HTRANS_IDLE; m1_htrans = `HTRANS_IDLE; reset = 1'b1;
    sample();
    check("t5_held_m1_hready", 64'(m1_hready), 64'd0);
    next_cycle();
    reset = 1'b0;
    sample();
    check("t5_htrans", 64'(s_htrans), 64'(`HTRANS_IDLE));
    check("t5_m0_hready", 64'(m0_hready), 64'd1);
    check("t5_m1_hready", 64'(m1_hready), 64'd1);
    next_cycle();
    sample();
    check("t5_no_stale_htrans", 64'(s_htrans), 64'(`HTRANS_IDLE));
    check("t5_no_stale_m1_hresp", 64'(m1_hresp), 64'd0);

    // 6: round-robin instance, both masters requesting every cycle; m1 locks for a while
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    m0_req(32'hA0, 1'b0); m1_req(32'hB0, 1'b0);
    sample();
    check("t6_c0", 64'(r_s_haddr), 64'hA0);
    check("t6_c0_fixed", 64'(s_haddr), 64'hA0);
    next_cycle();
    sample();
    check("t6_c1", 64'(r_s_haddr), 64'hB0);
    next_cycle();
    m1_hmastlock = 1'b1;
    sample();
    check("t6_c2", 64'(r_s_haddr), 64'hA0);
    next_cycle();
    sample();
    check("t6_c3", 64'(r_s_haddr), 64'hB0);
    check("t6_c3_lock", 64'(r_s_hmastlock), 64'd1);
    next_cycle();
    sample();
    check("t6_c4_locked", 64'(r_s_haddr), 64'hB0);
    check("t6_c4_m0_hready", 64'(r_m0_hready), 64'd0);
    next_cycle();
    m1_hmastlock = 1'b0;
    sample();
    check("t6_c5_locked", 64'(r_s_haddr), 64'hB0);
    next_cycle();
    sample();
    check("t6_c6", 64'(r_s_haddr), 64'hA0);
    next_cycle();
    sample();
    check("t6_c7", 64'(r_s_haddr), 64'hB0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
